// File: rtl/spi_slave_sequencer_pkg.sv
// spi_slave_sequencer_pkg: FSM state encodings, channel IDs and default sizing shared by the sequencer files.
package spi_slave_sequencer_pkg;
  typedef enum logic [2:0] {ST_IDLE, ST_SETUP, ST_SHIFT, ST_DONE, ST_GAP} state_t;
  localparam logic CH1 = 1'b0;
  localparam logic CH2 = 1'b1;
  localparam int DEF_DATA_W = 8;
  localparam int DEF_CLK_DIV = 2;
  localparam int DEF_CNT_W = 8;
endpackage

// File: rtl/spi_shift_engine.sv
// spi_shift_engine: SPI mode 0 bit engine; CLK_DIV-cycle setup, then DATA_W low/high sclk periods, MSB first.
module spi_shift_engine #(
  parameter int DATA_W = 8,
  parameter int CLK_DIV = 2,
  parameter int CNT_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [DATA_W-1:0] tx_word,
  input  logic              miso,
  output logic              sclk,
  output logic              mosi,
  output logic [DATA_W-1:0] rx_word,
  output logic              last_bit
);
  localparam int BW = $clog2(DATA_W) + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLK_DIV - 1);
  localparam logic [BW-1:0] BIT_MAX = BW'(DATA_W - 1);
  logic run_q, run_d, setup_q, setup_d, sclk_q, sclk_d, mosi_q, mosi_d, tick;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [BW-1:0] bit_q, bit_d;
  logic [DATA_W-1:0] sh_q, sh_d;
  assign tick = run_q && cnt_q == CNT_MAX;
  assign last_bit = tick && !setup_q && sclk_q && bit_q == BIT_MAX;
  // one register serves both directions: miso enters on the rise, mosi takes the new MSB on the fall
  always_comb begin
    run_d = run_q;
    setup_d = setup_q;
    sclk_d = sclk_q;
    mosi_d = mosi_q;
    bit_d = bit_q;
    sh_d = sh_q;
    cnt_d = (run_q && !tick) ? cnt_q + 1'b1 : '0;
    if (start) begin
      run_d = 1'b1;
      setup_d = 1'b1;
      sclk_d = 1'b0;
      mosi_d = tx_word[DATA_W-1];
      bit_d = '0;
      sh_d = tx_word;
    end else if (tick && setup_q) begin
      setup_d = 1'b0;
    end else if (tick && !sclk_q) begin
      sclk_d = 1'b1;
      sh_d = {sh_q[DATA_W-2:0], miso};
    end else if (tick) begin
      sclk_d = 1'b0;
      bit_d = bit_q + 1'b1;
      mosi_d = !last_bit && sh_q[DATA_W-1];
      run_d = !last_bit;
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      run_q <= 1'b0;
      setup_q <= 1'b0;
      sclk_q <= 1'b0;
      mosi_q <= 1'b0;
      bit_q <= '0;
      cnt_q <= '0;
      sh_q <= '0;
    end else begin
      run_q <= run_d;
      setup_q <= setup_d;
      sclk_q <= sclk_d;
      mosi_q <= mosi_d;
      bit_q <= bit_d;
      cnt_q <= cnt_d;
      sh_q <= sh_d;
    end
  end
  assign sclk = sclk_q;
  assign mosi = mosi_q;
  assign rx_word = sh_q;
endmodule

// File: rtl/spi_slave_sequencer.sv
// spi_slave_sequencer: round-robin sharing of one SPI master bus between two slaves (ss1/ss2).
// Define SPI_SEQ_CS_GAP_EN to add a 2*CLK_DIV deselect gap after every transfer.
module spi_slave_sequencer
  import spi_slave_sequencer_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int CLK_DIV = DEF_CLK_DIV,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req1,
  input  logic [DATA_W-1:0] tx_data1,
  output logic [DATA_W-1:0] rx_data1,
  output logic              done1,
  input  logic              req2,
  input  logic [DATA_W-1:0] tx_data2,
  output logic [DATA_W-1:0] rx_data2,
  output logic              done2,
  output logic              busy,
  output logic              sclk,
  output logic              mosi,
  input  logic              miso,
  output logic              ss1,
  output logic              ss2
);
  localparam logic [CNT_W:0] SETUP_END = (CNT_W+1)'(CLK_DIV - 1);
`ifdef SPI_SEQ_CS_GAP_EN
  localparam logic [CNT_W:0] GAP_END = (CNT_W+1)'(2 * CLK_DIV - 1);
`endif
  state_t state_q, state_d;
  logic ch_q, ch_d, last_q, last_d, start, gnt, last_bit, act;
  logic [CNT_W:0] cnt_q, cnt_d;
  logic [DATA_W-1:0] rx1_q, rx1_d, rx2_q, rx2_d, tx_word, rx_word;
  assign gnt = (req1 && req2) ? ~last_q : (req1 ? CH1 : CH2);
  assign tx_word = gnt == CH1 ? tx_data1 : tx_data2;
  always_comb begin
    state_d = state_q;
    ch_d = ch_q;
    last_d = last_q;
    rx1_d = rx1_q;
    rx2_d = rx2_q;
    start = 1'b0;
    case (state_q)
      ST_IDLE: if (req1 || req2) begin
        start = 1'b1;
        ch_d = gnt;
        state_d = ST_SETUP;
      end
      ST_SETUP: state_d = cnt_q == SETUP_END ? ST_SHIFT : ST_SETUP;
      ST_SHIFT: if (last_bit) begin
        state_d = ST_DONE;
        rx1_d = ch_q == CH1 ? rx_word : rx1_q;
        rx2_d = ch_q == CH2 ? rx_word : rx2_q;
      end
`ifdef SPI_SEQ_CS_GAP_EN
      ST_DONE: begin
        last_d = ch_q;
        state_d = ST_GAP;
      end
      ST_GAP: state_d = cnt_q == GAP_END ? ST_IDLE : ST_GAP;
`else
      ST_DONE: begin
        last_d = ch_q;
        state_d = ST_IDLE;
      end
`endif
      default: state_d = ST_IDLE;
    endcase
    cnt_d = state_d != state_q ? '0 : cnt_q + 1'b1;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      ch_q <= CH1;
      last_q <= CH2;
      cnt_q <= '0;
      rx1_q <= '0;
      rx2_q <= '0;
    end else begin
      state_q <= state_d;
      ch_q <= ch_d;
      last_q <= last_d;
      cnt_q <= cnt_d;
      rx1_q <= rx1_d;
      rx2_q <= rx2_d;
    end
  end
  spi_shift_engine #(.DATA_W(DATA_W), .CLK_DIV(CLK_DIV), .CNT_W(CNT_W)) u_eng (
    .clk(clk),
    .reset(reset),
    .start(start),
    .tx_word(tx_word),
    .miso(miso),
    .sclk(sclk),
    .mosi(mosi),
    .rx_word(rx_word),
    .last_bit(last_bit)
  );
  assign act = state_q == ST_SETUP || state_q == ST_SHIFT;
  assign ss1 = !(act && ch_q == CH1);
  assign ss2 = !(act && ch_q == CH2);
  assign busy = state_q != ST_IDLE;
  assign done1 = state_q == ST_DONE && ch_q == CH1;
  assign done2 = state_q == ST_DONE && ch_q == CH2;
  assign rx_data1 = rx1_q;
  assign rx_data2 = rx2_q;
endmodule

// File: tb/tb_spi_slave_sequencer.sv
// tb_spi_slave_sequencer: randomized transfers against a transaction-level model of arbitration, timing and data.
module tb_spi_slave_sequencer;
  localparam int DW = 8;
  localparam int CD = 2;
  localparam int LAT = CD + 2 * CD * DW + 1;
`ifdef SPI_SEQ_CS_GAP_EN
  localparam int GAP_HI = 2 + 2 * CD;
`else
  localparam int GAP_HI = 2;
`endif
  logic clk = 0, reset = 1, req1 = 0, req2 = 0, miso;
  logic [DW-1:0] tx_data1 = '0, tx_data2 = '0, sw1 = '0, sw2 = '0, rx_data1, rx_data2;
  logic done1, done2, busy, sclk, mosi, ss1, ss2;
  logic sclk_prev = 0, busy_prev = 0;
  int checks = 0, failures = 0, cyc = 0, rise_cnt = 0, model_last = 2;
  int overlap = 0, sclk_idle = 0, ss1_low = 0, ss2_low = 0;
  int g_cyc[$];
  int d_ch[$];
  int d_lat[$];
  logic [DW-1:0] d_rx[$];
  logic mosi_bits[$];

  spi_slave_sequencer #(.DATA_W(DW), .CLK_DIV(CD), .CNT_W(8)) dut (
    .clk(clk), .reset(reset),
    .req1(req1), .tx_data1(tx_data1), .rx_data1(rx_data1), .done1(done1),
    .req2(req2), .tx_data2(tx_data2), .rx_data2(rx_data2), .done2(done2),
    .busy(busy), .sclk(sclk), .mosi(mosi), .miso(miso), .ss1(ss1), .ss2(ss2)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic slave_bit(logic [DW-1:0] w, int n);
    return n < DW ? w[DW-1-n] : 1'b0;
  endfunction
  assign miso = !ss1 ? slave_bit(sw1, rise_cnt) : (!ss2 ? slave_bit(sw2, rise_cnt) : 1'b0);

  // bus monitor: selects, sclk rises, grants and done pulses
  always @(negedge clk) begin
    if (!ss1 && !ss2) overlap++;
    if (ss1 && ss2 && sclk) sclk_idle++;
    if (!ss1) ss1_low++;
    if (!ss2) ss2_low++;
    if (ss1 && ss2) rise_cnt = 0;
    else if (sclk && !sclk_prev) begin
      mosi_bits.push_back(mosi);
      rise_cnt++;
    end
    if (busy && !busy_prev) g_cyc.push_back(cyc - 1);
    if (done1) begin
      d_ch.push_back(1);
      d_lat.push_back(cyc - (g_cyc.size() > 0 ? g_cyc[$] : 0));
      d_rx.push_back(rx_data1);
    end
    if (done2) begin
      d_ch.push_back(2);
      d_lat.push_back(cyc - (g_cyc.size() > 0 ? g_cyc[$] : 0));
      d_rx.push_back(rx_data2);
    end
    sclk_prev = sclk;
    busy_prev = busy;
  end

  function automatic int pick(bit r1, bit r2, int last);
    return (r1 && r2) ? (last == 1 ? 2 : 1) : (r1 ? 1 : 2);
  endfunction

  task automatic tick(int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic wait_done(int target, output bit ok);
    int n = 0;
    while (d_ch.size() < target && n < 300) begin
      tick(1);
      n++;
    end
    ok = d_ch.size() >= target;
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL done_timeout: got %0d done pulses, required %0d", d_ch.size(), target);
    end
  endtask

  task automatic run_batch(bit r1, bit r2, logic [DW-1:0] t1, logic [DW-1:0] t2, logic [DW-1:0] w1, logic [DW-1:0] w2);
    int d0 = d_ch.size(), b0 = mosi_bits.size(), ov = overlap, si = sclk_idle;
    int n = int'(r1) + int'(r2);
    bit p1 = r1, p2 = r2, ok;
    tx_data1 = t1;
    tx_data2 = t2;
    sw1 = w1;
    sw2 = w2;
    req1 = r1;
    req2 = r2;
    for (int k = 0; k < n; k++) begin
      int exp_ch = pick(p1, p2, model_last);
      logic [DW-1:0] exp_rx = exp_ch == 1 ? w1 : w2;
      logic [DW-1:0] exp_tx = exp_ch == 1 ? t1 : t2;
      logic [DW-1:0] port_rx = exp_ch == 1 ? rx_data1 : rx_data2;
      logic [DW-1:0] mw = '0;
      wait_done(d0 + k + 1, ok);
      if (!ok) break;
      port_rx = exp_ch == 1 ? rx_data1 : rx_data2;
      for (int i = 0; i < DW; i++)
        mw = {mw[DW-2:0], (b0 + DW * k + i < mosi_bits.size()) ? mosi_bits[b0 + DW * k + i] : 1'bx};
      checks += 5;
      if (d_ch[d0+k] !== exp_ch) begin failures++; $display("FAIL grant_order: got ch%0d, required ch%0d", d_ch[d0+k], exp_ch); end
      if (d_lat[d0+k] !== LAT) begin failures++; $display("FAIL latency: got %0d, required %0d", d_lat[d0+k], LAT); end
      if (d_rx[d0+k] !== exp_rx) begin failures++; $display("FAIL rx_at_done: got %h, required %h", d_rx[d0+k], exp_rx); end
      if (port_rx !== exp_rx) begin failures++; $display("FAIL rx_port: got %h, required %h", port_rx, exp_rx); end
      if (mw !== exp_tx) begin failures++; $display("FAIL mosi_word: got %h, required %h", mw, exp_tx); end
      model_last = exp_ch;
      if (exp_ch == 1) begin p1 = 0; req1 = 0; end
      else begin p2 = 0; req2 = 0; end
    end
    req1 = 0;
    req2 = 0;
    tick(3);
    checks += 4;
    if (d_ch.size() !== d0 + n) begin failures++; $display("FAIL done_count: got %0d, required %0d", d_ch.size() - d0, n); end
    if (overlap !== ov) begin failures++; $display("FAIL ss_overlap: got %0d cycles, required 0", overlap - ov); end
    if (sclk_idle !== si) begin failures++; $display("FAIL sclk_deselected: got %0d cycles, required 0", sclk_idle - si); end
    if (busy !== 1'b0) begin failures++; $display("FAIL busy_after: got %b, required 0", busy); end
  endtask

  task automatic test_reset;
    int d0, g0;
    reset = 1;
    tick(2);
    checks += 3;
    if ({ss1, ss2, sclk, mosi, busy, done1, done2} !== 7'b1100000) begin
      failures++; $display("FAIL reset_outputs: got %b, required 1100000", {ss1, ss2, sclk, mosi, busy, done1, done2});
    end
    if (rx_data1 !== '0) begin failures++; $display("FAIL reset_rx1: got %h, required 00", rx_data1); end
    if (rx_data2 !== '0) begin failures++; $display("FAIL reset_rx2: got %h, required 00", rx_data2); end
    reset = 0;
    model_last = 2;
    d0 = d_ch.size();
    g0 = g_cyc.size();
    tick(50);
    checks += 3;
    if ({ss1, ss2, sclk, busy} !== 4'b1100) begin failures++; $display("FAIL idle_outputs: got %b, required 1100", {ss1, ss2, sclk, busy}); end
    if (d_ch.size() !== d0) begin failures++; $display("FAIL idle_done: got %0d pulses, required 0", d_ch.size() - d0); end
    if (g_cyc.size() !== g0) begin failures++; $display("FAIL idle_grant: got %0d grants, required 0", g_cyc.size() - g0); end
  endtask

  task automatic test_single_ch1;
    int s1 = ss1_low, s2 = ss2_low;
    run_batch(1, 0, 8'hA5, DW'($urandom), 8'h3C, DW'($urandom));
    checks += 2;
    if (ss1_low - s1 !== LAT - 1) begin failures++; $display("FAIL ss1_low_cycles: got %0d, required %0d", ss1_low - s1, LAT - 1); end
    if (ss2_low - s2 !== 0) begin failures++; $display("FAIL ss2_low_cycles: got %0d, required 0", ss2_low - s2); end
  endtask

  task automatic test_simultaneous;
    reset = 1;
    req1 = 1;
    req2 = 1;
    tick(2);
    model_last = 2;
    reset = 0;
    run_batch(1, 1, DW'($urandom), DW'($urandom), DW'($urandom), DW'($urandom));
  endtask

  task automatic test_fairness;
    int d0 = d_ch.size();
    bit ok;
    sw1 = DW'($urandom);
    sw2 = DW'($urandom);
    req1 = 1;
    req2 = 1;
    for (int k = 0; k < 4; k++) begin
      int exp_ch = pick(1, 1, model_last);
      wait_done(d0 + k + 1, ok);
      if (!ok) break;
      checks += 2;
      if (d_ch[d0+k] !== exp_ch) begin failures++; $display("FAIL fair_order%0d: got ch%0d, required ch%0d", k, d_ch[d0+k], exp_ch); end
      if (d_rx[d0+k] !== (exp_ch == 1 ? sw1 : sw2)) begin failures++; $display("FAIL fair_rx%0d: got %h, required %h", k, d_rx[d0+k], exp_ch == 1 ? sw1 : sw2); end
      model_last = exp_ch;
    end
    req1 = 0;
    req2 = 0;
    tick(CD * 4 + 3);
  endtask

  task automatic test_random;
    repeat (6) begin
      int pat = $urandom_range(1, 3);
      run_batch(pat[0], pat[1], DW'($urandom), DW'($urandom), DW'($urandom), DW'($urandom));
    end
  endtask

  task automatic test_back_to_back;
    int d0 = d_ch.size(), n_hi = 0, n_nb = 0, guard = 0;
    bit ok;
    tx_data1 = DW'($urandom);
    sw1 = DW'($urandom);
    req1 = 1;
    wait_done(d0 + 1, ok);
    while (ok && ss1 && guard < 50) begin
      n_hi++;
      if (!busy) n_nb++;
      guard++;
      tick(1);
    end
    wait_done(d0 + 2, ok);
    req1 = 0;
    model_last = 1;
    tick(CD * 4 + 3);
    checks += 4;
    if (n_hi !== GAP_HI) begin failures++; $display("FAIL deselect_gap: got %0d cycles, required %0d", n_hi, GAP_HI); end
    if (n_nb !== 1) begin failures++; $display("FAIL busy_gap: got %0d idle cycles, required 1", n_nb); end
    if (ok && d_rx[d0+1] !== sw1) begin failures++; $display("FAIL b2b_rx: got %h, required %h", d_rx[d0+1], sw1); end
    if (d_ch.size() !== d0 + 2) begin failures++; $display("FAIL b2b_count: got %0d, required 2", d_ch.size() - d0); end
  endtask

  task automatic test_reset_mid;
    int n = 0, d0;
    tx_data2 = DW'($urandom);
    sw2 = DW'($urandom);
    req2 = 1;
    d0 = d_ch.size();
    while (rise_cnt != 4 && n < 200) begin
      tick(1);
      n++;
    end
    checks++;
    if (rise_cnt != 4) begin failures++; $display("FAIL reach_bit4: got %0d rises, required 4", rise_cnt); end
    reset = 1;
    #1;
    checks += 2;
    if ({ss1, ss2, sclk, mosi, busy, done2} !== 6'b110000) begin
      failures++; $display("FAIL async_reset: got %b, required 110000", {ss1, ss2, sclk, mosi, busy, done2});
    end
    if (rx_data2 !== '0) begin failures++; $display("FAIL reset_rx2_mid: got %h, required 00", rx_data2); end
    req2 = 0;
    tick(2);
    reset = 0;
    model_last = 2;
    tick(40);
    checks++;
    if (d_ch.size() !== d0) begin failures++; $display("FAIL aborted_done: got %0d pulses, required 0", d_ch.size() - d0); end
    run_batch(0, 1, DW'($urandom), DW'($urandom), DW'($urandom), DW'($urandom));
  endtask

  initial begin
    test_reset;
    test_single_ch1;
    test_simultaneous;
    test_fairness;
    test_random;
    test_back_to_back;
    test_reset_mid;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
